// File: rtl/aftab_csr_rmw_sequencer.sv
// aftab_csr_rmw_sequencer: multi-cycle CSR read-modify-write sequencer with privilege/read-only checks and user-view mirroring
module aftab_csr_rmw_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] USTATUS_MASK = 32'h0000_0011,
  parameter logic [XLEN-1:0] UIE_MASK = 32'h0000_0111,
  parameter logic [XLEN-1:0] UIP_MASK = 32'h0000_0111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [11:0]     csrAddr,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1Field,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [1:0]      privMode,
  input  logic [XLEN-1:0] rdData,
  output logic            csrRdEn,
  output logic [11:0]     csrRdAddr,
  output logic            csrWrEn,
  output logic [11:0]     csrWrAddr,
  output logic [XLEN-1:0] csrWrData,
  output logic            ldMieReg,
  output logic            ldMieUieField,
  output logic [XLEN-1:0] rdResult,
  output logic            busy,
  output logic            done,
  output logic            illegal
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, FAULT} stateT;
  stateT state, nextState;
  logic [11:0] addrQ, physAddr;
  logic [XLEN-1:0] maskQ, physMask, rs1DataQ, oldQ, src, mod;
  logic [2:0] funct3Q;
  logic [4:0] rs1FieldQ;
  logic wrReq, wrReqQ, fault, isUser;
  assign isUser = csrAddr[11:8] == 4'h0;
  assign physAddr = isUser && csrAddr[7:0] == 8'h00 ? 12'h300 :
                    isUser && csrAddr[7:0] == 8'h04 ? 12'h304 :
                    isUser && csrAddr[7:0] == 8'h44 ? 12'h344 : csrAddr;
  assign physMask = isUser && csrAddr[7:0] == 8'h00 ? USTATUS_MASK :
                    isUser && csrAddr[7:0] == 8'h04 ? UIE_MASK :
                    isUser && csrAddr[7:0] == 8'h44 ? UIP_MASK : '1;
  assign wrReq = funct3[1:0] == 2'b01 || rs1Field != 5'd0;
  assign fault = funct3[1:0] == 2'b00 || csrAddr[9:8] > privMode || (csrAddr[11:10] == 2'b11 && wrReq);
  assign src = funct3Q[2] ? {{(XLEN-5){1'b0}}, rs1FieldQ} : rs1DataQ;
  assign mod = funct3Q[1:0] == 2'b01 ? src : funct3Q[1:0] == 2'b10 ? (oldQ | src) : (oldQ & ~src);
  assign csrRdEn = state == READ && !rst;
  assign csrRdAddr = addrQ;
  assign csrWrEn = state == WRITE && wrReqQ && !rst;
  assign csrWrAddr = addrQ;
  assign csrWrData = state == WRITE ? ((oldQ & ~maskQ) | (mod & maskQ)) : '0;
  assign ldMieReg = csrWrEn && addrQ == 12'h304;
  assign ldMieUieField = csrWrEn && addrQ == 12'h300;
  assign busy = state != IDLE;
  assign done = (state == DONE || state == FAULT) && !rst;
  assign illegal = state == FAULT && !rst;
  // next-state sequencing; IDLE branches on the fault decision made at accept time
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = start ? (fault ? FAULT : READ) : IDLE;
      READ:    nextState = WAIT;
      WAIT:    nextState = WRITE;
      WRITE:   nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  // state register plus operand latch, old-value capture and rd result update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addrQ <= '0;
      maskQ <= '0;
      funct3Q <= '0;
      rs1FieldQ <= '0;
      rs1DataQ <= '0;
      wrReqQ <= 1'b0;
      oldQ <= '0;
      rdResult <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        addrQ <= physAddr;
        maskQ <= physMask;
        funct3Q <= funct3;
        rs1FieldQ <= rs1Field;
        rs1DataQ <= rs1Data;
        wrReqQ <= wrReq;
      end
      if (state == WAIT) oldQ <= rdData;
      if (state == WRITE) rdResult <= oldQ & maskQ;
    end
  end
endmodule

// File: tb/tb_aftab_csr_rmw_sequencer.sv
// tb_aftab_csr_rmw_sequencer: directed checks of the CSR read-modify-write sequencer against a simple bank model
module tb_aftab_csr_rmw_sequencer;
  logic clk = 1'b0, rst, start;
  logic [11:0] csrAddr, csrRdAddr, csrWrAddr;
  logic [2:0] funct3;
  logic [4:0] rs1Field;
  logic [31:0] rs1Data, rdData, csrWrData, rdResult;
  logic [1:0] privMode;
  logic csrRdEn, csrWrEn, ldMieReg, ldMieUieField, busy, done, illegal;
  logic pokeEn = 1'b0;
  logic [11:0] pokeAddr = '0;
  logic [31:0] pokeData = '0;
  logic [31:0] bank [0:4095];
  logic obsRd [0:15], obsWr [0:15], obsDone [0:15], obsIll [0:15], obsBusy [0:15], obsLdMie [0:15], obsLdUie [0:15];
  logic [11:0] obsRdAddr [0:15], obsWrAddr [0:15];
  logic [31:0] obsWrData [0:15], obsRes [0:15];
  int nChk = 0, nPass = 0;

  aftab_csr_rmw_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .csrAddr(csrAddr), .funct3(funct3),
    .rs1Field(rs1Field), .rs1Data(rs1Data), .privMode(privMode), .rdData(rdData),
    .csrRdEn(csrRdEn), .csrRdAddr(csrRdAddr), .csrWrEn(csrWrEn), .csrWrAddr(csrWrAddr),
    .csrWrData(csrWrData), .ldMieReg(ldMieReg), .ldMieUieField(ldMieUieField),
    .rdResult(rdResult), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // CSR bank model: registered read data, write on strobe, preload port for setup
  always @(posedge clk) begin
    if (pokeEn) bank[pokeAddr] <= pokeData;
    if (csrRdEn) rdData <= bank[csrRdAddr];
    if (csrWrEn) bank[csrWrAddr] <= csrWrData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  task automatic run(input logic [11:0] a, input logic [2:0] f, input logic [4:0] r, input logic [31:0] d,
                     input logic [1:0] p, input int hold, input int rstAt, input int n);
    @(negedge clk);
    csrAddr = a; funct3 = f; rs1Field = r; rs1Data = d; privMode = p; start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = k < hold;
      rst = k == rstAt;
      #1;
      obsRd[k] = csrRdEn; obsWr[k] = csrWrEn; obsDone[k] = done; obsIll[k] = illegal;
      obsBusy[k] = busy; obsLdMie[k] = ldMieReg; obsLdUie[k] = ldMieUieField;
      obsRdAddr[k] = csrRdAddr; obsWrAddr[k] = csrWrAddr; obsWrData[k] = csrWrData; obsRes[k] = rdResult;
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int sumOf(input logic v [0:15], input int n);
    int s = 0;
    for (int k = 1; k <= n; k++) s += int'(v[k]);
    return s;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; csrAddr = '0; funct3 = '0; rs1Field = '0; rs1Data = '0; privMode = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_rden", csrRdEn, 0);
    check("rst_wren", csrWrEn, 0);
    check("rst_result", rdResult, 0);
    rst = 1'b0;
    poke(12'h340, 32'h0000_00F0);
    poke(12'h304, 32'h0000_0888);
    poke(12'h300, 32'h0000_1800);
    poke(12'hC00, 32'h0000_1234);

    run(12'h340, 3'b010, 5'd1, 32'h0F, 2'b11, 1, 0, 6);
    check("rs_rden1", obsRd[1], 1);
    check("rs_rdaddr1", obsRdAddr[1], 32'h340);
    check("rs_busy2", obsBusy[2], 1);
    check("rs_wren3", obsWr[3], 1);
    check("rs_wraddr3", obsWrAddr[3], 32'h340);
    check("rs_wrdata3", obsWrData[3], 32'hFF);
    check("rs_done3", obsDone[3], 0);
    check("rs_done4", obsDone[4], 1);
    check("rs_result4", obsRes[4], 32'hF0);
    check("rs_busy5", obsBusy[5], 0);

    run(12'h300, 3'b010, 5'd1, 32'h0, 2'b00, 1, 0, 4);
    check("priv_ill1", obsIll[1], 1);
    check("priv_done1", obsDone[1], 1);
    check("priv_busy2", obsBusy[2], 0);
    check("priv_rdcnt", sumOf(obsRd, 4), 0);
    check("priv_result", obsRes[2], 32'hF0);

    run(12'h004, 3'b111, 5'h10, 32'h0, 2'b00, 1, 0, 6);
    check("rci_rdaddr1", obsRdAddr[1], 32'h304);
    check("rci_wren3", obsWr[3], 1);
    check("rci_wrdata3", obsWrData[3], 32'h888);
    check("rci_ldmie3", obsLdMie[3], 1);
    check("rci_lduie3", obsLdUie[3], 0);
    check("rci_result4", obsRes[4], 32'h0);

    run(12'h000, 3'b001, 5'd5, 32'hFFFF_FFFF, 2'b00, 1, 0, 6);
    check("rw_wraddr3", obsWrAddr[3], 32'h300);
    check("rw_wrdata3", obsWrData[3], 32'h0000_1811);
    check("rw_lduie3", obsLdUie[3], 1);
    check("rw_ldmie3", obsLdMie[3], 0);
    check("rw_result4", obsRes[4], 32'h0);

    run(12'hC00, 3'b001, 5'd1, 32'h0, 2'b11, 1, 0, 3);
    check("ro_ill1", obsIll[1], 1);

    run(12'hC00, 3'b010, 5'd0, 32'hFFFF_FFFF, 2'b11, 1, 0, 6);
    check("ro_rd_illcnt", sumOf(obsIll, 6), 0);
    check("ro_rd_rden1", obsRd[1], 1);
    check("ro_rd_wrcnt", sumOf(obsWr, 6), 0);
    check("ro_rd_result4", obsRes[4], 32'h1234);

    run(12'h340, 3'b000, 5'd1, 32'h0, 2'b11, 1, 0, 3);
    check("f3_ill1", obsIll[1], 1);

    run(12'h340, 3'b001, 5'd1, 32'hAAAA, 2'b11, 1, 2, 6);
    check("rst2_wrcnt", sumOf(obsWr, 6), 0);
    check("rst2_busy3", obsBusy[3], 0);

    run(12'h340, 3'b001, 5'd1, 32'hBBBB, 2'b11, 1, 3, 6);
    check("rst3_wren3", obsWr[3], 0);
    check("rst3_busy4", obsBusy[4], 0);

    run(12'h340, 3'b001, 5'd1, 32'hCCCC, 2'b11, 1, 1, 4);
    check("rst1_rdcnt", sumOf(obsRd, 4), 0);
    check("rst1_busy2", obsBusy[2], 0);

    run(12'h340, 3'b010, 5'd0, 32'h0, 2'b11, 11, 0, 10);
    check("hold_donecnt", sumOf(obsDone, 10), 2);
    check("hold_done4", obsDone[4], 1);
    check("hold_done9", obsDone[9], 1);
    check("hold_rdcnt", sumOf(obsRd, 10), 2);
    check("hold_rden6", obsRd[6], 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule

// File: doc/aftab_csr_rmw_sequencer.md
# aftab_csr_rmw_sequencer

Multi-cycle control unit for AFTAB CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms). It performs a read-modify-write sequence against the CSR register bank and checks privilege and read-only violations. User-level views (ustatus/uie/uip) are redirected onto their machine-level counterparts (mstatus/mie/mip) under parametrised field masks. It sits between the main controller and the CSR register bank, and drives the mie/mstatus load strobes consumed by the interrupt logic.

## Interface
Parameters:
- XLEN, 32, data width
- USTATUS_MASK, 32'h0000_0011, mstatus bits visible through ustatus (UIE, UPIE)
- UIE_MASK, 32'h0000_0111, mie bits visible through uie
- UIP_MASK, 32'h0000_0111, mip bits visible through uip

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request; accepted only in IDLE
- csrAddr  in  12  CSR address from instruction
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- rs1Field  in  5  rs1 index, or uimm for the immediate forms
- rs1Data  in  XLEN  rs1 register value
- privMode  in  2  current privilege (00 U, 01 S, 11 M)
- rdData  in  XLEN  bank read data, valid one cycle after csrRdEn
- csrRdEn  out  1  bank read strobe
- csrRdAddr  out  12  physical read address
- csrWrEn  out  1  bank write strobe
- csrWrAddr  out  12  physical write address
- csrWrData  out  XLEN  write data
- ldMieReg  out  1  pulse with csrWrEn when the physical address is 12'h304
- ldMieUieField  out  1  pulse with csrWrEn when the physical address is 12'h300
- rdResult  out  XLEN  old CSR value for rd; held until the next accepted start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse, coincident with done, on a faulting access

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE, FAULT. Reset state is IDLE. All outputs are 0 at reset; rdResult is 0.
- IDLE with start=1: latch csrAddr, funct3, rs1Field, rs1Data and the fault decision.
  - If a fault is detected, go to FAULT. Otherwise go to READ.
- Fault conditions (any one):
  - funct3 is 000 or 100.
  - csrAddr[9:8] > privMode.
  - csrAddr[11:10]==2'b11 and a write is required.
- Write required: always for RW/RWI. For RS/RC/RSI/RCI, only when rs1Field != 0.
- Mirror map: csrAddr[11:8]==4'h0 with low byte 00/04/44 maps to physical 300/304/344 with mask USTATUS/UIE/UIP_MASK. Any other address maps to itself with mask all-ones.
- READ: csrRdEn=1, csrRdAddr=physical address.
- WAIT: capture old = rdData.
- WRITE:
  - src = funct3[2] ? {XLEN-5 zeros, rs1Field} : rs1Data.
  - mod = src (RW), old|src (RS), old&~src (RC).
  - csrWrData = (old & ~mask) | (mod & mask).
  - csrWrEn=1 only if a write is required. ldMie* strobes follow csrWrEn.
- DONE: done=1, rdResult = old & mask. Next state is IDLE.
- FAULT: done=1, illegal=1. No read or write is issued, and rdResult is unchanged. Next state is IDLE.
- start while busy is ignored and is not queued.

## Timing
- start sampled in cycle 0.
- Normal path: READ in cycle 1, WAIT in cycle 2, WRITE in cycle 3, done in cycle 4, IDLE in cycle 5. A new start is accepted in cycle 5.
- Fault path: done and illegal in cycle 1, IDLE in cycle 2.
- busy is high in cycles 1..4 (normal path) or cycle 1 (fault path).
- rst high in any cycle:
  - forces csrWrEn, csrRdEn, done and illegal to 0 in that same cycle (gated).
  - state is IDLE from the next cycle. An interrupted sequence never writes.
- A start and rst in the same cycle: rst wins and start is dropped.
- rdResult updates only in the DONE cycle.

## Test plan
- mscratch 0x340 = 0x0000_00F0, CSRRS, rs1Data=0x0F, privMode=11:
  - cycle 3: csrWrData=0xFF with csrWrEn=1.
  - cycle 4: done=1, rdResult=0xF0.
- CSRRCI to 0x004 with uimm=0x10, mie=0x888:
  - csrRdAddr=0x304.
  - csrWrData=0x888 (bit 4 already clear; bit 11 preserved).
  - ldMieReg=1.
  - rdResult=0x0.
- CSRRW to 0x000, rs1Data=0xFFFF_FFFF, mstatus=0x0000_1800:
  - csrWrAddr=0x300, csrWrData=0x0000_1811.
  - ldMieUieField=1.
  - rdResult=0x0.
- Fault cases:
  - CSRRS to 0x300 with privMode=00 gives illegal=done=1 in cycle 1, and csrRdEn never asserts.
  - CSRRW to read-only 0xC00 with privMode=11 faults.
  - CSRRS to 0xC00 with rs1Field=0 does not fault; it reads with no write.
- rst asserted in cycle 2 of a CSRRW: csrWrEn stays 0, and busy=0 from cycle 3.
- start held high continuously: exactly one sequence per 5 cycles, and the extra starts during busy are ignored.
